serial_word_tx: RTL and testbench

Parallel-in, serial-out word transmitter: it accepts a W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. Its serial stream feeds the shift-left register block's `shin`/`shl` inputs directly, so that block reassembles the word at the far end. The transmitter sits between a word-producing datapath and a serial link.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_word_tx_piso_shreg.sv | 35 +++
 rtl/serial_word_tx.sv | 115 +++++++++++
 tb/tb_serial_word_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial word link (transmitter and receiver side).
// Parity frame support is compiled in with SERIAL_TX_PARITY_EN.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_tx_piso_shreg.sv
// Load / shift-left register with zero fill; exposes only the MSB tap
// that feeds the serial output.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift) begin
      q_d = {q_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign msb = q_q[W-1];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter, MSB first, valid/ready input.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         sout,
  output logic         sout_en,
  output logic         last,
  output tx_state_t    dbg_state
);

  // Handshake: a word transfers on a rising edge where valid_in && ready_out
  // && !clr; the producer holds d and valid_in until that edge.
  localparam int CW = cnt_w(W);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          tap;
  logic          final_bit;

  assign final_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign accept    = valid_in && ready_out && !clr;
  assign dbg_state = state_q;

`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_d;

  assign ready_out = (state_q == IDLE) || (state_q == PARITY);
  assign last      = (state_q == PARITY);
  assign sout_en   = (state_q == SHIFT) || (state_q == PARITY);
  assign sout      = (state_q == SHIFT)  ? tap   :
                     (state_q == PARITY) ? par_q : 1'b0;
`else
  assign ready_out = (state_q == IDLE) || final_bit;
  assign last      = final_bit;
  assign sout_en   = (state_q == SHIFT);
  // Gated so a word left over after an abort never leaks onto the link.
  assign sout      = (state_q == SHIFT) && tap;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      cnt_d = CW'(W - 1);
`ifdef SERIAL_TX_PARITY_EN
      par_d = ^d;
`endif
    end
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = accept ? SHIFT : IDLE;
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          state_d = accept ? SHIFT : IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  piso_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_q == SHIFT),
    .d     (d),
    .msb   (tap)
  );

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed steps plus random frames checked
// against a bit-stream model and a word-level receiver model.
module tb_serial_word_tx;
  import serial_pkg::*;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] d = '0;
  logic         valid_in = 1'b0;
  logic         ready_out, sout, sout_en, last;
  tx_state_t    dbg_state;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  logic         bit_q[$];
  logic [W-1:0] rx;

  serial_word_tx #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .d         (d),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .sout      (sout),
    .sout_en   (sout_en),
    .last      (last),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends n (1 or 2) words back-to-back, starting from idle, and checks
  // every bit against the model stream and the reassembled word.
  task automatic send_frames(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] ws[2];
    logic         expb;
    int           pos;
    ws[0] = w0;
    ws[1] = w1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(ws[k]);
      for (int b = W - 1; b >= 0; b--) bit_q.push_back(ws[k][b]);
      if (PAR == 1) bit_q.push_back(^ws[k]);
    end
    chk("ready_before", ready_out, 1'b1);
    d = ws[0];
    valid_in = 1'b1;
    step();
    for (int i = 0; i < n * FL; i++) begin
      if (i == 0) begin
        if (n == 2) d = ws[1];
        else valid_in = 1'b0;
      end
      if (i == FL) valid_in = 1'b0;
      pos = i % FL;
      expb = bit_q.pop_front();
      chk("sout_en", sout_en, 1'b1);
      chk("sout", sout, expb);
      chk("last", last, pos == FL - 1);
      chk("ready_out", ready_out, pos == FL - 1);
      if (pos < W) rx = {rx[W-2:0], sout};
      if (pos == W - 1) chk("rx_word", rx, exp_q.pop_front());
      step();
    end
    chk("idle_en", sout_en, 1'b0);
    chk("idle_last", last, 1'b0);
    chk("idle_state", dbg_state, IDLE);
  endtask

  initial begin
    // Reset with a pending handshake: nothing may transfer.
    rst = 1'b1;
    valid_in = 1'b1;
    d = 8'hA5;
    repeat (3) step();
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_en", sout_en, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    send_frames(1, 8'hA5, '0);
    send_frames(2, 8'hFF, 8'h00);

    // Abort in the third bit of 8'h3C.
    d = 8'h3C;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (2) step();
    chk("abort_bit3_en", sout_en, 1'b1);
    chk("abort_bit3", sout, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort_en", sout_en, 1'b0);
    chk("abort_rdy", ready_out, 1'b1);
    chk("abort_state", dbg_state, IDLE);
    for (int i = 0; i < FL; i++) begin
      chk("abort_last", last, 1'b0);
      chk("abort_sout", sout, 1'b0);
      step();
    end

    // clr together with a handshake: the word must be refused.
    d = 8'h5A;
    valid_in = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    valid_in = 1'b0;
    chk("clr_hs_en", sout_en, 1'b0);
    chk("clr_hs_state", dbg_state, IDLE);
    step();
    chk("clr_hs_en2", sout_en, 1'b0);
    send_frames(1, 8'h3C, '0);

    // Asynchronous reset during bit 5.
    d = 8'hC3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    chk("mrst_pre_en", sout_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_en", sout_en, 1'b0);
    chk("mrst_sout", sout, 1'b0);
    chk("mrst_last", last, 1'b0);
    chk("mrst_rdy", ready_out, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk("mrst_after_en", sout_en, 1'b0);
    chk("mrst_after_state", dbg_state, IDLE);

`ifdef SERIAL_TX_PARITY_EN
    send_frames(1, 8'h07, '0);
    send_frames(1, 8'h03, '0);
`endif

    // Random frames with random idle gaps.
    for (int it = 0; it < 12; it++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_en", sout_en, 1'b0);
      end
      send_frames($urandom_range(1, 2), W'($urandom), W'($urandom));
    end

    chk("model_drained", bit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
